// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared defaults and constant helpers for the input conditioner
package input_conditioner_pkg;
  localparam int DEF_N_CH = 5;
  localparam int DEF_STAGES = 3;
  localparam int DEF_DB_COUNT = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_width(input int db);
    return clog2(db) > 1 ? clog2(db) : 1;
  endfunction
endpackage

// File: rtl/synchroniser_ns.sv
// synchroniser_ns: enable-gated multi-stage synchroniser for one asynchronous bit
module synchroniser_ns import input_conditioner_pkg::*; #(
  parameter int STAGES = DEF_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in,
  output logic out
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk)
    if (reset) chain <= '0;
    else if (en) chain <= {chain[STAGES-2:0], in};
  assign out = chain[STAGES-1];
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronise, debounce and edge-pulse generation
module input_conditioner import input_conditioner_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int STAGES = DEF_STAGES,
  parameter int DB_COUNT = DEF_DB_COUNT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);
  localparam int CW = cnt_width(DB_COUNT);
  localparam logic [CW-1:0] LAST = CW'(DB_COUNT - 1);
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] flip;
  logic [CW-1:0] cnt [N_CH];
  if (N_CH < 1 || STAGES < 2 || DB_COUNT < 1) begin : g_bad_param
    $error("input_conditioner: requires N_CH>=1, STAGES>=2, DB_COUNT>=1");
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    synchroniser_ns #(.STAGES(STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .in   (in[i]),
      .out  (s[i])
    );
  end
  // a channel flips once its mismatch has persisted for DB_COUNT enabled samples
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_CH; i++) flip[i] = en && (s[i] != out[i]) && (cnt[i] == LAST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      out <= out ^ flip;
      rise <= flip & s;
      fall <= flip & ~s;
      if (en)
        for (int i = 0; i < N_CH; i++)
          cnt[i] <= (s[i] == out[i] || flip[i]) ? '0 : cnt[i] + CW'(1);
    end
  end
endmodule
